pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the architectural PC and sequences instruction fetch for the LEGv8 core.
//  Issues req/ack fetches to instruction memory and presents each instruction to decode.
//  On retire, it applies the branch resolution through NextPCLogic: PC+4, or PC+(imm<<2)
//  when taken. It also detects fetch timeouts and misaligned targets.
// PARAMETERS
//  RESET_VECTOR  64'h0  PC loaded on reset
//  IMEM_TIMEOUT  15     REQ cycles without ImemAck before fault (1..255)
// PORTS
//  CLK           in   1   clock, all state on rising edge
//  Reset_L       in   1   reset, synchronous, active-low
//  ImemReq       out  1   fetch request valid
//  ImemAddr      out  64  fetch address (= CurrentPC while ImemReq)
//  ImemAck       in   1   fetch response valid, qualifies ImemData
//  ImemData      in   32  fetched instruction word
//  InstValid     out  1   Inst valid for decode
//  Inst          out  32  latched instruction
//  InstAccept    in   1   core retires Inst; resolution inputs sampled this cycle
//  Branch        in   1   conditional branch (CBZ)
//  ALUZero       in   1   ALU zero flag
//  Uncondbranch  in   1   unconditional branch (B)
//  SignExtImm64  in   64  sign-extended word offset
//  Halt          in   1   sampled with InstAccept; stop after this instruction
//  CurrentPC     out  64  architectural PC
//  State         out  3   FSM state, for debug
//  FetchErr      out  1   sticky fault flag
//  RetiredCnt    out  32  retired-instruction count (PERF_CNT_EN)
//  TakenCnt      out  32  taken-branch count (PERF_CNT_EN)
// BEHAVIOUR
//  Reset (Reset_L=0 at an edge, any state, mid-fetch included):
//   - State=IDLE, CurrentPC=RESET_VECTOR, Inst=0.
//   - ImemReq, InstValid, FetchErr, and both counters all go to 0.
//   - An ack that arrives in the reset cycle is ignored.
//  FSM:
//   - IDLE: one cycle, then REQ.
//   - REQ: ImemReq=1 and ImemAddr=CurrentPC, held stable until ImemAck.
//     An ack in the first REQ cycle is legal. On ack: Inst<=ImemData, go to DEC.
//   - DEC: InstValid=1 and Inst held until InstAccept. Imem inputs are ignored.
//   - On accept:
//     - CurrentPC <= NextPC; go to REQ, or to HALT if Halt=1.
//     - If NextPC[1:0]!=0: go to ERR and leave CurrentPC unchanged.
//   - HALT: ImemReq=0, InstValid=0, PC frozen; exit only by reset.
//   - ERR: FetchErr=1, ImemReq=0, InstValid=0; exit only by reset.
//   - Timeout: the counter clears on REQ entry and counts each REQ cycle without ack.
//     Reaching IMEM_TIMEOUT goes to ERR. An ack arriving on the same cycle wins.
//  NextPC (arithmetic, wraps mod 2^64):
//   - taken = Uncondbranch | (Branch & ALUZero)
//   - taken: CurrentPC + {SignExtImm64[61:0],2'b00}; else CurrentPC + 4
//  Latency:
//   - InstAccept at edge n: ImemReq with the new address at cycle n+1.
//   - Zero-wait memory: 2 cycles per instruction.
//  Branch inputs are don't-care when InstAccept=0.
//  InstAccept asserted outside DEC is ignored.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   - RetiredCnt += 1 per accepted instruction; TakenCnt += 1 when taken.
//   - Both wrap at 2^32 and clear on reset.
//  PERF_CNT_EN undefined: RetiredCnt and TakenCnt tied to 32'd0, no counter flops.
// STRUCTURE
//  Package pc_seq_pkg:
//   - State encodings IDLE=0, REQ=1, DEC=2, HALT=3, ERR=4.
//   - ADDR_W=64, INST_W=32, PC_STEP=4.
//  Sub-module: existing NextPCLogic instantiated for the NextPC compute.
//  Everything else (FSM, timeout counter, perf counters) stays in this module.
// TESTING
//  1. Reset with RESET_VECTOR=0, ack 1 cycle after each req, accept with no branch
//     -> ImemAddr sequence 0,4,8; RetiredCnt=3.
//  2. PC=180, accept with Uncondbranch=1, imm=3 -> next ImemAddr=192; TakenCnt+1.
//  3. PC=180, Branch=1, imm=-3: ALUZero=1 -> 168; ALUZero=0 -> 184.
//  4. IMEM_TIMEOUT=15, ImemAck held 0 -> FetchErr=1 after 15 REQ cycles.
//     Ack on cycle 15 instead -> no fault.
//  5. Accept with Halt=1 at PC=8 -> HALT, CurrentPC=12, ImemReq=0 indefinitely.
//     Reset mid-REQ -> PC=RESET_VECTOR, counters=0, fault cleared.
//  6. SignExtImm64 = 64'h4000_0000_0000_0000 (shift drops top bits)
//     -> target = PC+0 (wraps), no fault.
//     PC=64'hFFFF_FFFF_FFFF_FFFC, not taken -> next ImemAddr=0 (wrap).

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the LEGv8 fetch sequencer.
// State encodings are visible on the State debug port, so their values are fixed.
package pc_seq_pkg;

  localparam int ADDR_W  = 64;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_DEC  = 3'd2,
    ST_HALT = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  function automatic logic branch_taken(input logic uncond, input logic branch, input logic zero);
    return uncond | (branch & zero);
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch bus to instruction memory plus the decode/retire handshake with the core.
// master = sequencer side, slave = memory/core side.
interface pc_fetch_sequencer_if;
  import pc_seq_pkg::*;

  logic              ImemReq;
  logic [ADDR_W-1:0] ImemAddr;
  logic              ImemAck;
  logic [INST_W-1:0] ImemData;
  logic              InstValid;
  logic [INST_W-1:0] Inst;
  logic              InstAccept;
  logic              Branch;
  logic              ALUZero;
  logic              Uncondbranch;
  logic [ADDR_W-1:0] SignExtImm64;
  logic              Halt;

  modport master (
    output ImemReq, ImemAddr, InstValid, Inst,
    input  ImemAck, ImemData, InstAccept, Branch, ALUZero, Uncondbranch, SignExtImm64, Halt
  );

  modport slave (
    input  ImemReq, ImemAddr, InstValid, Inst,
    output ImemAck, ImemData, InstAccept, Branch, ALUZero, Uncondbranch, SignExtImm64, Halt
  );

endinterface

// File: rtl/NextPCLogic.sv
// Branch-resolved next PC: PC+4, or PC plus the word offset when the branch is taken.
// Shifting the full 64-bit offset drops its top two bits, giving the mod 2^64 wrap.
module NextPCLogic
  import pc_seq_pkg::*;
(
  input  logic [ADDR_W-1:0] CurrentPC,
  input  logic [ADDR_W-1:0] SignExtImm64,
  input  logic              Branch,
  input  logic              ALUZero,
  input  logic              Uncondbranch,
  output logic [ADDR_W-1:0] NextPC
);

  always_comb begin
    if (branch_taken(Uncondbranch, Branch, ALUZero)) begin
      NextPC = CurrentPC + (SignExtImm64 << 2);
    end else begin
      NextPC = CurrentPC + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Owns the architectural PC and sequences req/ack instruction fetch for decode.
// Optional build macro PERF_CNT_EN adds retired and taken-branch counters.
//
// state | meaning
// IDLE  | one cycle after reset before the first fetch
// REQ   | fetch outstanding at CurrentPC, timeout running
// DEC   | instruction presented to decode, waiting for retire
// HALT  | stopped by a retired Halt, left only by reset
// ERR   | fetch timeout or misaligned target, left only by reset
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       IMEM_TIMEOUT = 15
) (
  input  logic                 CLK,
  input  logic                 Reset_L,
  pc_fetch_sequencer_if.master fetch,
  output logic [ADDR_W-1:0]    CurrentPC,
  output logic [2:0]           State,
  output logic                 FetchErr,
  output logic [31:0]          RetiredCnt,
  output logic [31:0]          TakenCnt
);

  localparam logic [7:0] TMO_LOAD = 8'(IMEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;
  logic [7:0]        tmo_q;
  logic [ADDR_W-1:0] next_pc;
  logic              enter_req;
  logic              fetch_done;
  logic              accept;
  logic              pc_load;

  NextPCLogic u_next_pc (
    .CurrentPC    (pc_q),
    .SignExtImm64 (fetch.SignExtImm64),
    .Branch       (fetch.Branch),
    .ALUZero      (fetch.ALUZero),
    .Uncondbranch (fetch.Uncondbranch),
    .NextPC       (next_pc)
  );

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    enter_req  = 1'b0;
    fetch_done = 1'b0;
    accept     = 1'b0;
    pc_load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d   = ST_REQ;
        enter_req = 1'b1;
      end
      ST_REQ: begin
        // An ack on the terminal-count cycle still completes the fetch.
        if (fetch.ImemAck) begin
          state_d    = ST_DEC;
          fetch_done = 1'b1;
        end else if (tmo_q == '0) begin
          state_d = ST_ERR;
        end
      end
      ST_DEC: begin
        if (fetch.InstAccept) begin
          accept = 1'b1;
          if (next_pc[1:0] != 2'b00) begin
            state_d = ST_ERR;
          end else begin
            pc_load = 1'b1;
            if (fetch.Halt) begin
              state_d = ST_HALT;
            end else begin
              state_d   = ST_REQ;
              enter_req = 1'b1;
            end
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      pc_q   <= RESET_VECTOR;
      inst_q <= '0;
      tmo_q  <= '0;
    end else begin
      if (fetch_done) inst_q <= fetch.ImemData;
      if (pc_load)    pc_q   <= next_pc;
      if (enter_req) begin
        tmo_q <= TMO_LOAD;
      end else if (state_q == ST_REQ && tmo_q != '0) begin
        tmo_q <= tmo_q - 8'd1;
      end
    end
  end

  assign fetch.ImemReq   = (state_q == ST_REQ);
  assign fetch.ImemAddr  = pc_q;
  assign fetch.InstValid = (state_q == ST_DEC);
  assign fetch.Inst      = inst_q;
  assign CurrentPC       = pc_q;
  assign State           = state_q;
  assign FetchErr        = (state_q == ST_ERR);

`ifdef PERF_CNT_EN
  logic [31:0] retired_q, taken_q;

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else if (accept) begin
      retired_q <= retired_q + 32'd1;
      if (branch_taken(fetch.Uncondbranch, fetch.Branch, fetch.ALUZero)) begin
        taken_q <= taken_q + 32'd1;
      end
    end
  end

  assign RetiredCnt = retired_q;
  assign TakenCnt   = taken_q;
`else
  assign RetiredCnt = 32'd0;
  assign TakenCnt   = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: branch-vector table, multi-cycle
// corner sequences (halt, timeout, reset) and a randomized run against a PC model.
module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic [63:0] CurrentPC;
  logic [2:0]  State;
  logic        FetchErr;
  logic [31:0] RetiredCnt, TakenCnt;

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] m_pc;
  logic [31:0] m_ret, m_tak;

  pc_fetch_sequencer_if fetch();

  pc_fetch_sequencer #(.RESET_VECTOR(64'h0), .IMEM_TIMEOUT(15)) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .fetch      (fetch.master),
    .CurrentPC  (CurrentPC),
    .State      (State),
    .FetchErr   (FetchErr),
    .RetiredCnt (RetiredCnt),
    .TakenCnt   (TakenCnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        unc;
    logic        br;
    logic        zero;
    logic [63:0] imm;
    logic [63:0] exp_next;
  } vec_t;

  vec_t vt[13];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic garbage_branch();
    fetch.Branch       = 1'($urandom);
    fetch.ALUZero      = 1'($urandom);
    fetch.Uncondbranch = 1'($urandom);
    fetch.SignExtImm64 = {$urandom, $urandom};
    fetch.Halt         = 1'($urandom);
  endtask

  task automatic do_reset();
    fetch.ImemAck    = 1'b0;
    fetch.InstAccept = 1'b0;
    Reset_L = 1'b0;
    step();
    Reset_L = 1'b1;
    step();
    m_pc = 64'h0; m_ret = 0; m_tak = 0;
  endtask

  // Entered in a REQ cycle; leaves the DUT in DEC with data latched.
  task automatic do_fetch(input logic [31:0] data, input int dly);
    for (int i = 0; i < dly; i++) begin
      fetch.ImemAck    = 1'b0;
      fetch.ImemData   = $urandom;
      fetch.InstAccept = 1'($urandom);
      garbage_branch();
      chk("req_valid", 64'(fetch.ImemReq), 64'd1);
      chk("req_addr", fetch.ImemAddr, m_pc);
      step();
    end
    fetch.ImemAck    = 1'b1;
    fetch.ImemData   = data;
    fetch.InstAccept = 1'($urandom);
    garbage_branch();
    chk("req_addr", fetch.ImemAddr, m_pc);
    step();
    fetch.ImemAck    = 1'b0;
    fetch.InstAccept = 1'b0;
    chk("dec_valid", {62'd0, fetch.InstValid, fetch.ImemReq}, 64'd2);
    chk("dec_inst", 64'(fetch.Inst), 64'(data));
  endtask

  task automatic do_accept(input logic [31:0] data, input int dly, input logic unc,
                           input logic br, input logic zero, input logic [63:0] imm,
                           input logic halt, input logic [63:0] exp_next);
    for (int i = 0; i < dly; i++) begin
      fetch.InstAccept = 1'b0;
      fetch.ImemAck    = 1'($urandom);
      fetch.ImemData   = $urandom;
      garbage_branch();
      step();
      chk("dec_hold", {31'd0, fetch.InstValid, fetch.Inst}, {31'd0, 1'b1, data});
    end
    fetch.ImemAck      = 1'b0;
    fetch.InstAccept   = 1'b1;
    fetch.Uncondbranch = unc;
    fetch.Branch       = br;
    fetch.ALUZero      = zero;
    fetch.SignExtImm64 = imm;
    fetch.Halt         = halt;
    step();
    fetch.InstAccept = 1'b0;
    fetch.Halt       = 1'b0;
    m_ret++;
    if (unc || (br && zero)) m_tak++;
    m_pc = exp_next;
    if (halt) begin
      chk("halt_state", 64'(State), 64'd3);
      chk("halt_pc", CurrentPC, exp_next);
    end else begin
      chk("next_req", {63'd0, fetch.ImemReq}, 64'd1);
      chk("next_addr", fetch.ImemAddr, exp_next);
    end
    chk("retired_cnt", 64'(RetiredCnt), 64'(cnt_exp(m_ret)));
    chk("taken_cnt", 64'(TakenCnt), 64'(cnt_exp(m_tak)));
  endtask

  initial begin
    int bad;
    vt[0]  = '{1'b0, 1'b0, 1'b0, 64'd0,                  64'd4};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 64'd0,                  64'd8};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 64'd43,                 64'd180};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 64'd3,                  64'd192};
    vt[4]  = '{1'b1, 1'b0, 1'b0, -64'd3,                 64'd180};
    vt[5]  = '{1'b0, 1'b1, 1'b1, -64'd3,                 64'd168};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 64'd3,                  64'd180};
    vt[7]  = '{1'b0, 1'b1, 1'b0, -64'd3,                 64'd184};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 64'd100,                64'd188};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 64'h4000_0000_0000_0000, 64'd188};
    vt[10] = '{1'b1, 1'b1, 1'b1, 64'd2,                  64'd196};
    vt[11] = '{1'b1, 1'b0, 1'b0, -64'd50,                64'hFFFF_FFFF_FFFF_FFFC};
    vt[12] = '{1'b0, 1'b0, 1'b0, 64'd0,                  64'd0};

    fetch.ImemAck = 1'b0; fetch.ImemData = '0; fetch.InstAccept = 1'b0;
    fetch.Branch = 1'b0; fetch.ALUZero = 1'b0; fetch.Uncondbranch = 1'b0;
    fetch.SignExtImm64 = '0; fetch.Halt = 1'b0;

    // Reset state
    Reset_L = 1'b0;
    step(); step();
    chk("rst_state", 64'(State), 64'd0);
    chk("rst_pc", CurrentPC, 64'd0);
    chk("rst_inst", 64'(fetch.Inst), 64'd0);
    chk("rst_flags", {61'd0, fetch.ImemReq, fetch.InstValid, FetchErr}, 64'd0);
    chk("rst_cnt", {RetiredCnt, TakenCnt}, 64'd0);
    Reset_L = 1'b1;
    step();
    chk("idle_to_req", {61'd0, State}, 64'd1);
    m_pc = 64'h0; m_ret = 0; m_tak = 0;

    // Branch-resolution vector table
    for (int i = 0; i < 13; i++) begin
      do_fetch(32'hA000_0000 + 32'(i), i % 3);
      do_accept(32'hA000_0000 + 32'(i), i % 2, vt[i].unc, vt[i].br, vt[i].zero,
                vt[i].imm, 1'b0, vt[i].exp_next);
    end

    // Halt at PC=8
    do_reset();
    do_fetch(32'h1111_0000, 0); do_accept(32'h1111_0000, 0, 0, 0, 0, 0, 0, 64'd4);
    do_fetch(32'h1111_0004, 0); do_accept(32'h1111_0004, 0, 0, 0, 0, 0, 0, 64'd8);
    do_fetch(32'h1111_0008, 1); do_accept(32'h1111_0008, 1, 0, 0, 0, 0, 1, 64'd12);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      fetch.ImemAck = 1'($urandom); fetch.InstAccept = 1'($urandom);
      garbage_branch();
      step();
      if (fetch.ImemReq !== 1'b0 || fetch.InstValid !== 1'b0 || CurrentPC !== 64'd12) bad++;
    end
    chk("halt_frozen", 64'(bad), 64'd0);

    // Timeout: 15 REQ cycles without ack
    do_reset();
    fetch.ImemAck = 1'b0;
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      if (State !== 3'd1 || FetchErr !== 1'b0) bad++;
      step();
    end
    chk("tmo_req_held", 64'(bad), 64'd0);
    chk("tmo_err", {60'd0, State, FetchErr}, {60'd0, 3'd4, 1'b1});
    chk("tmo_quiet", {62'd0, fetch.ImemReq, fetch.InstValid}, 64'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      fetch.ImemAck = 1'($urandom); fetch.InstAccept = 1'($urandom);
      step();
      if (FetchErr !== 1'b1) bad++;
    end
    chk("err_sticky", 64'(bad), 64'd0);
    fetch.ImemAck = 1'b0; fetch.InstAccept = 1'b0;
    Reset_L = 1'b0;
    step();
    chk("err_cleared", {60'd0, State, FetchErr}, 64'd0);

    // Ack on the 15th REQ cycle wins over the timeout
    do_reset();
    for (int k = 1; k <= 14; k++) step();
    fetch.ImemAck = 1'b1; fetch.ImemData = 32'h5A5A_0015;
    step();
    fetch.ImemAck = 1'b0;
    chk("ack15_dec", {60'd0, State, FetchErr}, {60'd0, 3'd2, 1'b0});
    do_accept(32'h5A5A_0015, 0, 0, 0, 0, 0, 0, 64'd4);

    // Reset mid-REQ with a simultaneous ack
    fetch.ImemAck = 1'b1; fetch.ImemData = 32'hDEAD_BEEF;
    Reset_L = 1'b0;
    step();
    fetch.ImemAck = 1'b0;
    chk("midreq_rst_state", 64'(State), 64'd0);
    chk("midreq_rst_pc", CurrentPC, 64'd0);
    chk("midreq_rst_inst", 64'(fetch.Inst), 64'd0);
    chk("midreq_rst_cnt", {RetiredCnt, TakenCnt}, 64'd0);
    Reset_L = 1'b1;
    step();
    m_pc = 64'h0; m_ret = 0; m_tak = 0;

    // Randomized run against the PC model
    for (int n = 0; n < 200; n++) begin
      logic [31:0] d;
      logic        u, b, z;
      longint      simm;
      logic [63:0] nxt;
      d = $urandom;
      u = 1'($urandom); b = 1'($urandom); z = 1'($urandom);
      simm = longint'($urandom_range(0, 127)) - 64;
      nxt = (u || (b && z)) ? m_pc + 64'(simm) * 64'd4 : m_pc + 64'd4;
      do_fetch(d, $urandom_range(0, 5));
      do_accept(d, $urandom_range(0, 3), u, b, z, 64'(simm), 1'b0, nxt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
